// File: rtl/lab7_pio_pkg.sv
// Shared definitions for the lab7 PIO master: FSM states, slave timing and PIO register map.
package lab7_pio_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        READ    = 2'd2,
        CAPTURE = 2'd3
    } pio_state_t;

    // Slave registers read data one clock after the select cycle.
    localparam int unsigned READ_LATENCY = 1;

    // Standard PIO register map (word addresses).
    localparam logic [1:0] PIO_DATA          = 2'd0;
    localparam logic [1:0] PIO_DIRECTION     = 2'd1;
    localparam logic [1:0] PIO_INTERRUPTMASK = 2'd2;
    localparam logic [1:0] PIO_EDGECAPTURE   = 2'd3;

endpackage

// File: rtl/lab7_poll_timer.sv
// Free-running poll interval timer; emits a one-cycle tick at terminal count while enabled.
module lab7_poll_timer #(
    parameter int unsigned POLL_PERIOD = 1000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    output logic tick
);

    localparam logic [15:0] TERMINAL = 16'(POLL_PERIOD - 1);

    logic [15:0] count;

    // Count 0..POLL_PERIOD-1 while enabled; clear and hold at zero when disabled.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (!enable || (count == TERMINAL)) begin
            count <= '0;
        end else begin
            count <= count + 16'd1;
        end
    end

    // Tick is combinational so the master sees it on the terminal-count cycle.
    always_comb begin
        tick = enable && (count == TERMINAL);
    end

endmodule

// File: rtl/lab7_pio_master.sv
// PIO master: serialises host commands and periodic input polls onto an Avalon-MM PIO slave.
module lab7_pio_master
    import lab7_pio_pkg::*;
#(
    parameter int unsigned POLL_PERIOD = 1000,
    parameter logic [1:0]  POLL_ADDR   = PIO_DATA
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_address,
    input  logic [31:0] cmd_writedata,
    output logic        rsp_valid,
    output logic [31:0] rsp_readdata,
    input  logic        poll_en,
    output logic        in_level,
    output logic        in_edge,
    output logic [1:0]  avm_address,
    output logic        avm_chipselect,
    output logic        avm_write_n,
    output logic [31:0] avm_writedata,
    input  logic [31:0] avm_readdata
);

    pio_state_t state, state_next;
    logic       poll_tick;
    logic       poll_pending;
    logic       op_is_poll;
    logic       accept_cmd;
    logic       accept_poll;

    lab7_poll_timer #(
        .POLL_PERIOD(POLL_PERIOD)
    ) u_poll_timer (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (poll_en),
        .tick   (poll_tick)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, arbitration (command beats poll) and bus strobes decoded from state.
    always_comb begin
        state_next  = state;
        accept_cmd  = 1'b0;
        accept_poll = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept_cmd = 1'b1;
                    state_next = cmd_write ? WRITE : READ;
                end else if (poll_pending) begin
                    accept_poll = 1'b1;
                    state_next  = READ;
                end
            end
            WRITE:   state_next = IDLE;
            READ:    state_next = CAPTURE;
            CAPTURE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        cmd_ready      = (state == IDLE);
        avm_chipselect = (state == WRITE) || (state == READ);
        avm_write_n    = (state != WRITE);
    end

    // Latch address/payload at acceptance; they hold through IDLE until the next access.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avm_address   <= '0;
            avm_writedata <= '0;
            op_is_poll    <= 1'b0;
        end else if (accept_cmd) begin
            avm_address <= cmd_address;
            op_is_poll  <= 1'b0;
            if (cmd_write) begin
                avm_writedata <= cmd_writedata;
            end
        end else if (accept_poll) begin
            avm_address <= POLL_ADDR;
            op_is_poll  <= 1'b1;
        end
    end

    // Single-entry poll request: a tick while one is already pending is absorbed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_pending <= 1'b0;
        end else if (!poll_en || accept_poll) begin
            poll_pending <= 1'b0;
        end else if (poll_tick) begin
            poll_pending <= 1'b1;
        end
    end

    // Sample read data at the end of CAPTURE and route it to the command or poll result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid    <= 1'b0;
            rsp_readdata <= '0;
            in_level     <= 1'b0;
            in_edge      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            in_edge   <= 1'b0;
            if (state == CAPTURE) begin
                if (op_is_poll) begin
                    in_level <= avm_readdata[0];
                    in_edge  <= avm_readdata[0] ^ in_level;
                end else begin
                    rsp_valid    <= 1'b1;
                    rsp_readdata <= avm_readdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_lab7_pio_master.sv
// Randomised bench for lab7_pio_master with a transaction-level reference model and a PIO slave.
module tb_lab7_pio_master;

    localparam int unsigned P     = 8;
    localparam logic [1:0]  PADDR = 2'd0;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_address = '0;
    logic [31:0] cmd_writedata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_readdata;
    logic        poll_en = 1'b0;
    logic        in_level;
    logic        in_edge;
    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = '0;

    always #5 clk = ~clk;

    lab7_pio_master #(
        .POLL_PERIOD(P),
        .POLL_ADDR  (PADDR)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_write     (cmd_write),
        .cmd_address   (cmd_address),
        .cmd_writedata (cmd_writedata),
        .rsp_valid     (rsp_valid),
        .rsp_readdata  (rsp_readdata),
        .poll_en       (poll_en),
        .in_level      (in_level),
        .in_edge       (in_edge),
        .avm_address   (avm_address),
        .avm_chipselect(avm_chipselect),
        .avm_write_n   (avm_write_n),
        .avm_writedata (avm_writedata),
        .avm_readdata  (avm_readdata)
    );

    int n_cmp = 0;
    int n_err = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endfunction

    // PIO slave: address 0 reads in_port / writes out_port, others are scratch words.
    logic [31:0] in_port = '0;
    logic [31:0] out_port = '0;
    logic [31:0] sl_mem [0:3] = '{default: '0};

    always @(posedge clk) begin
        if (avm_chipselect && avm_write_n) begin
            avm_readdata <= (avm_address == 2'd0) ? in_port : sl_mem[avm_address];
        end
        if (avm_chipselect && !avm_write_n) begin
            if (avm_address == 2'd0) out_port <= avm_writedata;
            else sl_mem[avm_address] <= avm_writedata;
        end
    end

    // Reference model: one access at a time, timed by edge numbers.
    // Access accepted at edge n: bus select in cycle n; read data lands at edge n+2;
    // master free again at edge n+2 (write) or n+3 (read).
    int          cyc = 0;
    int          ready_at = 0;
    int          acc_edge = -100;
    bit          acc_write = 1'b0;
    bit          acc_poll = 1'b0;
    logic [1:0]  m_addr = '0;
    logic [31:0] m_wdata = '0;
    logic [31:0] m_mem [0:3] = '{default: '0};
    logic [31:0] rd_val = '0;
    logic        m_rsp_valid = 1'b0;
    logic [31:0] m_rsp_data = '0;
    logic        m_level = 1'b0;
    logic        m_edge = 1'b0;
    bit          m_pending = 1'b0;
    int          en_run = 0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ready_at    = 0;
            acc_edge    = -100;
            acc_write   = 1'b0;
            acc_poll    = 1'b0;
            m_addr      = '0;
            m_wdata     = '0;
            m_rsp_valid = 1'b0;
            m_rsp_data  = '0;
            m_level     = 1'b0;
            m_edge      = 1'b0;
            m_pending   = 1'b0;
            en_run      = 0;
        end else begin
            bit take_poll;
            bit tick;
            cyc++;
            m_rsp_valid = 1'b0;
            m_edge      = 1'b0;
            take_poll   = 1'b0;
            if (!acc_write && (acc_edge + 2 == cyc)) begin
                if (acc_poll) begin
                    m_edge  = rd_val[0] ^ m_level;
                    m_level = rd_val[0];
                end else begin
                    m_rsp_valid = 1'b1;
                    m_rsp_data  = rd_val;
                end
            end
            if (!acc_write && (acc_edge + 1 == cyc)) begin
                rd_val = (m_addr == 2'd0) ? in_port : m_mem[m_addr];
            end
            if (cyc >= ready_at) begin
                if (cmd_valid) begin
                    acc_edge  = cyc;
                    acc_write = cmd_write;
                    acc_poll  = 1'b0;
                    m_addr    = cmd_address;
                    if (cmd_write) begin
                        m_wdata = cmd_writedata;
                        if (cmd_address != 2'd0) m_mem[cmd_address] = cmd_writedata;
                        ready_at = cyc + 2;
                    end else begin
                        ready_at = cyc + 3;
                    end
                end else if (m_pending) begin
                    take_poll = 1'b1;
                    acc_edge  = cyc;
                    acc_write = 1'b0;
                    acc_poll  = 1'b1;
                    m_addr    = PADDR;
                    ready_at  = cyc + 3;
                end
            end
            tick = poll_en && ((en_run % P) == P - 1);
            if (!poll_en) begin
                m_pending = 1'b0;
                en_run    = 0;
            end else begin
                if (take_poll) m_pending = 1'b0;
                else if (tick) m_pending = 1'b1;
                en_run++;
            end
        end
    end

    // Compare every output against the model on each falling edge outside reset.
    always @(negedge clk) begin
        if (reset_n) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(cyc + 1 >= ready_at));
            chk("chipselect", 32'(avm_chipselect), 32'(acc_edge == cyc));
            chk("write_n", 32'(avm_write_n), 32'(!((acc_edge == cyc) && acc_write)));
            chk("address", 32'(avm_address), 32'(m_addr));
            chk("writedata", avm_writedata, m_wdata);
            chk("rsp_valid", 32'(rsp_valid), 32'(m_rsp_valid));
            chk("rsp_readdata", rsp_readdata, m_rsp_data);
            chk("in_level", 32'(in_level), 32'(m_level));
            chk("in_edge", 32'(in_edge), 32'(m_edge));
        end
    end

    // Wait (bounded) for cmd_ready, present one command, drop it after acceptance.
    task automatic issue(input logic wr, input logic [1:0] addr, input logic [31:0] data);
        int t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("ready_wait", 32'(cmd_ready), 32'd1);
        cmd_valid     = 1'b1;
        cmd_write     = wr;
        cmd_address   = addr;
        cmd_writedata = data;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_cs"}, 32'(avm_chipselect), 32'd0);
        chk({tag, "_wn"}, 32'(avm_write_n), 32'd1);
        chk({tag, "_addr"}, 32'(avm_address), 32'd0);
        chk({tag, "_wdata"}, avm_writedata, 32'd0);
        chk({tag, "_rspv"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_rspd"}, rsp_readdata, 32'd0);
        chk({tag, "_level"}, 32'(in_level), 32'd0);
        chk({tag, "_edge"}, 32'(in_edge), 32'd0);
        chk({tag, "_ready"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int edges;
        int rsps;
        int reads;
        int wr_at;
        int rd_at;

        // Reset values.
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("por");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        // Write 1 to data register: bus strobes next cycle, out_port follows.
        issue(1'b1, 2'd0, 32'h0000_0001);
        chk("wr_cs", 32'(avm_chipselect), 32'd1);
        chk("wr_wn", 32'(avm_write_n), 32'd0);
        chk("wr_addr", 32'(avm_address), 32'd0);
        chk("wr_data", avm_writedata, 32'h0000_0001);
        @(posedge clk);
        #1;
        chk("out_port", out_port, 32'h0000_0001);

        // Reads of the data register with in_port = 1 then 0.
        for (int v = 1; v >= 0; v--) begin
            in_port = 32'(v);
            issue(1'b0, 2'd0, 32'h0);
            chk("rd_cs", 32'(avm_chipselect & avm_write_n), 32'd1);
            @(posedge clk);
            #1;
            chk("rsp_early", 32'(rsp_valid), 32'd0);
            @(posedge clk);
            #1;
            chk("rsp_on_time", 32'(rsp_valid), 32'd1);
            chk("rsp_value", rsp_readdata, 32'(v));
            @(posedge clk);
            #1;
            chk("rsp_one_pulse", 32'(rsp_valid), 32'd0);
        end

        // Auto-poll sees in_port rise: single edge pulse, no command response.
        repeat (2) @(negedge clk);
        in_port = 32'h1;
        poll_en = 1'b1;
        edges = 0;
        rsps = 0;
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk);
            #1;
            if (in_edge) edges++;
            if (rsp_valid) rsps++;
        end
        chk("poll_level", 32'(in_level), 32'd1);
        chk("poll_edges", 32'(edges), 32'd1);
        chk("poll_no_rsp", 32'(rsps), 32'd0);
        @(negedge clk);
        poll_en = 1'b0;

        // Command presented on the tick cycle runs first; exactly one poll follows.
        repeat (4) @(negedge clk);
        poll_en = 1'b1;
        repeat (7) @(negedge clk);
        cmd_valid     = 1'b1;
        cmd_write     = 1'b1;
        cmd_address   = 2'd1;
        cmd_writedata = 32'hA5A5_0001;
        reads = 0;
        wr_at = -1;
        rd_at = -1;
        for (int k = 8; k <= 14; k++) begin
            @(posedge clk);
            #1;
            if (k == 8) cmd_valid = 1'b0;
            if (k == 13) poll_en = 1'b0;
            if (avm_chipselect && !avm_write_n) wr_at = k;
            if (avm_chipselect && avm_write_n) begin
                reads++;
                rd_at = k;
            end
        end
        chk("arb_write_first", 32'(wr_at), 32'd8);
        chk("arb_poll_next", 32'(rd_at), 32'd10);
        chk("arb_one_poll", 32'(reads), 32'd1);

        // Randomised traffic against the model.
        repeat (3) @(negedge clk);
        poll_en = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            cmd_valid     = ($urandom_range(0, 99) < 40);
            cmd_write     = 1'($urandom_range(0, 1));
            cmd_address   = 2'($urandom_range(0, 3));
            cmd_writedata = $urandom;
            if ($urandom_range(0, 9) == 0) in_port = $urandom;
            if ($urandom_range(0, 199) == 0) poll_en = ~poll_en;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        poll_en   = 1'b0;

        // Reset asserted during READ aborts the access with no response.
        issue(1'b1, 2'd2, 32'hDEAD_BEEF);
        issue(1'b0, 2'd0, 32'h0);
        chk("abort_in_read", 32'(avm_chipselect & avm_write_n), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check_reset_values("abort");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        rsps = 0;
        edges = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) rsps++;
            if (in_edge) edges++;
        end
        chk("abort_no_rsp", 32'(rsps), 32'd0);
        chk("abort_no_edge", 32'(edges), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lab7_pio_master.md
LAB7_PIO_MASTER -- requirements
Module: lab7_pio_master

Interface
REQ-001 SHALL have parameter POLL_PERIOD, default 1000, poll interval in clk cycles (legal 2..65535).
REQ-002 SHALL have parameter POLL_ADDR, default 0, slave word address read by auto-poll.
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk input 1 system clock; reset_n input 1 asynchronous active-low reset.
REQ-004 cmd_valid  input  1  command request.
REQ-005 cmd_ready  output  1  command accepted when high with cmd_valid.
REQ-006 cmd_write  input  1  1 = write, 0 = read.
REQ-007 cmd_address  input  2  target word address.
REQ-008 cmd_writedata  input  32  write payload.
REQ-009 rsp_valid  output  1  one-cycle pulse, command read data valid.
REQ-010 rsp_readdata  output  32  command read result.
REQ-011 poll_en  input  1  enables periodic auto-poll.
REQ-012 in_level  output  1  bit 0 of last poll result.
REQ-013 in_edge  output  1  one-cycle pulse on in_level change.
REQ-014 avm_address  output  2  slave address.
REQ-015 avm_chipselect  output  1  slave select.
REQ-016 avm_write_n  output  1  slave write strobe, active low.
REQ-017 avm_writedata  output  32  slave write data.
REQ-018 avm_readdata  input  32  slave read data, registered in slave, 1-cycle read latency, no waitrequest.

Function
REQ-019 FSM states SHALL be IDLE, WRITE, READ, CAPTURE.
REQ-020 cmd_ready SHALL equal (state == IDLE); handshake = cmd_valid && cmd_ready on a rising clk edge.
REQ-021 Write accept -> WRITE for exactly 1 cycle: chipselect=1, write_n=0, address/writedata = latched command; then IDLE.
REQ-022 Read accept -> READ 1 cycle (chipselect=1, write_n=1, address driven) -> CAPTURE 1 cycle (chipselect=0), sample avm_readdata at end of CAPTURE -> IDLE.
REQ-023 Command read: rsp_valid SHALL pulse high the cycle after CAPTURE with rsp_readdata = sampled value; rsp_readdata holds until next command read.
REQ-024 Accept-to-rsp_valid latency SHALL be 3 cycles; back-to-back reads SHALL sustain one command per 3 cycles, writes one per 2.
REQ-025 Poll timer: free-running 0..POLL_PERIOD-1 while poll_en=1; at terminal count sets poll_pending; cleared and held at 0 when poll_en=0 (poll_pending also cleared).
REQ-026 In IDLE with poll_pending=1 and cmd_valid=0, FSM SHALL issue a poll read of POLL_ADDR via READ/CAPTURE; cmd_ready=0 throughout.
REQ-027 Simultaneous cmd_valid and poll_pending in IDLE: command wins; poll_pending SHALL persist and be served next IDLE cycle without cmd_valid; terminal count while pending SHALL not queue a second poll.
REQ-028 Poll completion: in_level <= avm_readdata[0]; in_edge pulses 1 cycle iff new value differs from previous in_level; rsp_valid SHALL NOT pulse for polls.
REQ-029 In IDLE: chipselect=0, write_n=1; address and writedata hold last driven values.
REQ-030 Never more than one slave access in flight; chipselect SHALL never be high in two consecutive cycles with write_n=1 between READ and CAPTURE.

Reset
REQ-031 reset_n low SHALL immediately force: state=IDLE, cmd_ready=1 after release, avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, rsp_valid=0, rsp_readdata=0, in_level=0, in_edge=0, poll counter=0, poll_pending=0.
REQ-032 Reset mid-transaction SHALL abort it with no rsp_valid and no in_edge afterwards for that transaction.

Structure
REQ-033 Shared package lab7_pio_pkg SHALL hold the state enum, READ_LATENCY=1, and PIO register address constants (DATA=0).
REQ-034 Poll timer SHALL be a sub-module lab7_poll_timer (inputs clk, reset_n, enable; output tick pulse).

Verification
REQ-035 Write cmd addr 0 data 0x1 -> next cycle chipselect=1, write_n=0, address=0, writedata=0x1; slave out_port=1 thereafter.
REQ-036 Read cmd addr 0, slave in_port=1 -> rsp_valid 3 cycles after accept, rsp_readdata=0x00000001; in_port=0 -> 0x00000000.
REQ-037 poll_en=1, POLL_PERIOD=8, in_port toggles 0->1 -> in_level=1 and single in_edge pulse within 8+3 cycles; no rsp_valid.
REQ-038 cmd_valid held high on poll tick cycle -> command executes first, poll read follows immediately after; exactly one poll.
REQ-039 reset_n asserted during READ -> chipselect=0 same cycle, no rsp_valid, all outputs at reset values.
